// File: rtl/video_field_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// video_seq_pkg
// Shared definitions for the interlaced PAL capture front end:
//   - state_t   : sequencer FSM states (IDLE / FIELD / LINE)
//   - PAL_*     : default active-window geometry and address field widths
//   - ADDR_W    : width of the packed pixel address {row, field, col}
//   - pack_addr : builds the packed pixel address for the default geometry
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package video_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIELD = 2'd1,
    LINE  = 2'd2
  } state_t;

  localparam int PAL_H_ACTIVE = 702;
  localparam int PAL_V_FIELD  = 288;
  localparam int PAL_COL_W    = 10;
  localparam int PAL_ROW_W    = 9;
  localparam int ADDR_W       = PAL_ROW_W + 1 + PAL_COL_W;

  // Row occupies the top bits so that both fields of a frame interleave
  // naturally when the address is used as a frame-buffer index.
  function automatic logic [ADDR_W-1:0] pack_addr(
    input logic [PAL_ROW_W-1:0] row,
    input logic                 field,
    input logic [PAL_COL_W-1:0] col
  );
    return {row, field, col};
  endfunction

endpackage

// File: rtl/video_field_sequencer_edge_detect.sv
// -----------------------------------------------------------------------------
// video_edge_detect
// Rise/fall detector for a synchronous level strobe, built on a one-cycle
// registered copy of the level.
// Ports:
//   clk     in  system clock
//   i_level in  level being watched (already synchronous to clk)
//   o_rise  out high in the first cycle the level is 1 after being 0
//   o_fall  out high in the first cycle the level is 0 after being 1
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module video_edge_detect (
  input  logic clk,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  // The delayed copy deliberately keeps tracking the input through reset:
  // a strobe that is held high across a reset is not a fresh edge, so the
  // sequencer waits for the next genuine rise instead of starting mid-field.
  logic r_level_d;

  always_ff @(posedge clk) begin
    r_level_d <= i_level;
  end

  assign o_rise = i_level & ~r_level_d;
  assign o_fall = ~i_level & r_level_d;

endmodule

// File: rtl/video_field_sequencer.sv
// -----------------------------------------------------------------------------
// video_field_sequencer
// Front-end controller for the interlaced PAL capture path. Tracks the
// frame/line/data strobes of the decoder interface, counts rows and columns
// inside each field, forwards qualified pixels with a packed address
// {row, field, col}, latches the processing mode once per frame and flags
// framing errors.
// Ports:
//   clk               in   system clock
//   rst               in   synchronous reset, active-high
//   mode_in           in   requested processing mode (sampled at field-0 start)
//   video_frame_valid in   high for the duration of one field
//   video_line_valid  in   high during one line's active region
//   video_data_valid  in   one-cycle pixel strobe
//   video_data_in     in   pixel value, valid with video_data_valid
//   pix_valid         out  qualified pixel strobe (1-cycle latency)
//   pix_data          out  registered pixel value
//   pix_addr          out  {row, field, col}
//   mode_active       out  mode applied to the current frame
//   field_start       out  one-cycle pulse at each field start
//   frame_done        out  one-cycle pulse at the end of field 1
//   line_err          out  one-cycle pulse: wrong line length or aborted line
//   field_err         out  one-cycle pulse: wrong line count at field end
//   busy              out  high while the sequencer is not idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module video_field_sequencer
  import video_seq_pkg::*;
#(
  parameter int H_ACTIVE = PAL_H_ACTIVE,
  parameter int V_ACTIVE = PAL_V_FIELD,
  parameter int COL_W    = PAL_COL_W,
  parameter int ROW_W    = PAL_ROW_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode_in,
  input  logic                     video_frame_valid,
  input  logic                     video_line_valid,
  input  logic                     video_data_valid,
  input  logic [7:0]               video_data_in,
  output logic                     pix_valid,
  output logic [7:0]               pix_data,
  output logic [ROW_W+COL_W:0]     pix_addr,
  output logic [1:0]               mode_active,
  output logic                     field_start,
  output logic                     frame_done,
  output logic                     line_err,
  output logic                     field_err,
  output logic                     busy
);

  localparam logic [COL_W-1:0] L_H_ACT = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0] L_V_ACT = ROW_W'(V_ACTIVE);

  // Counters saturate rather than wrap so that an overlong line or field can
  // never alias back onto valid addresses.
  function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] c);
    return (c == '1) ? c : c + COL_W'(1);
  endfunction

  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
    return (r == '1) ? r : r + ROW_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Strobe edge detection
  // ---------------------------------------------------------------------------
  logic w_fv_rise;
  logic w_fv_fall;
  logic w_lv_rise;
  logic w_lv_fall;

  video_edge_detect u_fv_edge (
    .clk     (clk),
    .i_level (video_frame_valid),
    .o_rise  (w_fv_rise),
    .o_fall  (w_fv_fall)
  );

  video_edge_detect u_lv_edge (
    .clk     (clk),
    .i_level (video_line_valid),
    .o_rise  (w_lv_rise),
    .o_fall  (w_lv_fall)
  );

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t                 r_state;
  logic                   r_field;
  logic [ROW_W-1:0]       r_row;
  logic [COL_W-1:0]       r_col;
  logic [1:0]             r_mode;
  logic                   r_pix_valid;
  logic [7:0]             r_pix_data;
  logic [ROW_W+COL_W:0]   r_pix_addr;
  logic                   r_field_start;
  logic                   r_frame_done;
  logic                   r_line_err;
  logic                   r_field_err;

  state_t                 w_state_n;
  logic                   w_field_n;
  logic [ROW_W-1:0]       w_row_n;
  logic [COL_W-1:0]       w_col_n;
  logic [1:0]             w_mode_n;
  logic                   w_pix_take;
  logic                   w_field_start_n;
  logic                   w_frame_done_n;
  logic                   w_line_err_n;
  logic                   w_field_err_n;
  logic [ROW_W-1:0]       w_row_inc;
  logic [ROW_W+COL_W:0]   w_addr;

  assign w_row_inc = row_inc(r_row);

  if (ROW_W == PAL_ROW_W && COL_W == PAL_COL_W) begin : g_pal_pack
    assign w_addr = pack_addr(r_row, r_field, r_col);
  end else begin : g_generic_pack
    assign w_addr = {r_row, r_field, r_col};
  end

  // ---------------------------------------------------------------------------
  // Next-state / pulse decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_n       = r_state;
    w_field_n       = r_field;
    w_row_n         = r_row;
    w_col_n         = r_col;
    w_mode_n        = r_mode;
    w_pix_take      = 1'b0;
    w_field_start_n = 1'b0;
    w_frame_done_n  = 1'b0;
    w_line_err_n    = 1'b0;
    w_field_err_n   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_fv_rise) begin
          w_state_n       = FIELD;
          w_field_start_n = 1'b1;
          w_row_n         = '0;
          w_col_n         = '0;
          // Mode only changes on a frame boundary so both fields of a frame
          // are processed identically.
          if (!r_field) begin
            w_mode_n = mode_in;
          end
        end
      end

      FIELD: begin
        if (w_fv_fall) begin
          w_state_n      = IDLE;
          w_field_err_n  = (r_row != L_V_ACT);
          w_frame_done_n = r_field;
          w_field_n      = ~r_field;
        end else if (w_lv_rise && video_frame_valid) begin
          w_state_n = LINE;
          w_col_n   = '0;
        end
      end

      LINE: begin
        if (w_lv_fall || w_fv_fall) begin
          // Line closes first; a frame fall with line_valid still high is an
          // aborted line and always reports line_err. The row is counted
          // before the field check so an aborted last line still counts.
          w_line_err_n = w_lv_fall ? (r_col != L_H_ACT) : 1'b1;
          w_row_n      = w_row_inc;
          if (w_fv_fall) begin
            w_state_n      = IDLE;
            w_field_err_n  = (w_row_inc != L_V_ACT);
            w_frame_done_n = r_field;
            w_field_n      = ~r_field;
          end else begin
            w_state_n = FIELD;
          end
        end else if (video_line_valid && video_data_valid) begin
          // Out-of-window pixels are dropped but still counted so the line
          // length check sees the true strobe count.
          w_pix_take = (r_col < L_H_ACT) && (r_row < L_V_ACT);
          w_col_n    = col_inc(r_col);
        end
      end

      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_field       <= 1'b0;
      r_row         <= '0;
      r_col         <= '0;
      r_mode        <= 2'b00;
      r_pix_valid   <= 1'b0;
      r_pix_data    <= '0;
      r_pix_addr    <= '0;
      r_field_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_line_err    <= 1'b0;
      r_field_err   <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_field       <= w_field_n;
      r_row         <= w_row_n;
      r_col         <= w_col_n;
      r_mode        <= w_mode_n;
      r_pix_valid   <= w_pix_take;
      r_field_start <= w_field_start_n;
      r_frame_done  <= w_frame_done_n;
      r_line_err    <= w_line_err_n;
      r_field_err   <= w_field_err_n;
      if (w_pix_take) begin
        r_pix_data <= video_data_in;
        r_pix_addr <= w_addr;
      end
    end
  end

  assign pix_valid   = r_pix_valid;
  assign pix_data    = r_pix_data;
  assign pix_addr    = r_pix_addr;
  assign mode_active = r_mode;
  assign field_start = r_field_start;
  assign frame_done  = r_frame_done;
  assign line_err    = r_line_err;
  assign field_err   = r_field_err;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_video_field_sequencer.sv
`timescale 1ns/1ps

module tb_video_field_sequencer;

  // Reduced geometry keeps whole fields short; address widths stay at the
  // PAL defaults so the {row, field, col} layout is unchanged.
  localparam int H = 16;
  localparam int V = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        fv;
  logic        lv;
  logic        dv;
  logic [7:0]  din;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic [19:0] pix_addr;
  logic [1:0]  mode_active;
  logic        field_start;
  logic        frame_done;
  logic        line_err;
  logic        field_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  video_field_sequencer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .COL_W    (10),
    .ROW_W    (9)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .mode_in           (mode),
    .video_frame_valid (fv),
    .video_line_valid  (lv),
    .video_data_valid  (dv),
    .video_data_in     (din),
    .pix_valid         (pix_valid),
    .pix_data          (pix_data),
    .pix_addr          (pix_addr),
    .mode_active       (mode_active),
    .field_start       (field_start),
    .frame_done        (frame_done),
    .line_err          (line_err),
    .field_err         (field_err),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Pulse/pixel recorder sampled on the falling edge.
  int          n_pix = 0;
  int          n_le  = 0;
  int          n_fe  = 0;
  int          n_fd  = 0;
  logic [19:0] addr_q[$];
  logic [7:0]  data_q[$];

  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      addr_q.push_back(pix_addr);
      data_q.push_back(pix_data);
      n_pix = n_pix + 1;
    end
    if (line_err === 1'b1)   n_le = n_le + 1;
    if (field_err === 1'b1)  n_fe = n_fe + 1;
    if (frame_done === 1'b1) n_fd = n_fd + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fv = 1'b0; lv = 1'b0; dv = 1'b0; din = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic frame_begin();
    fv = 1'b1;
    tick();
  endtask

  task automatic frame_end();
    fv = 1'b0;
    tick();
  endtask

  task automatic line_begin();
    lv = 1'b1;
    tick();
  endtask

  task automatic line_end();
    lv = 1'b0;
    tick();
  endtask

  task automatic strobes(input int n, input logic [7:0] d0);
    for (int i = 0; i < n; i++) begin
      dv  = 1'b1;
      din = d0 + 8'(i);
      tick();
    end
    dv = 1'b0;
  endtask

  task automatic full_lines(input int n);
    for (int r = 0; r < n; r++) begin
      line_begin();
      strobes(H, 8'(r * H));
      line_end();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [35:0] outs;
    int p;
    rst = 1'b1; fv = 1'b0; lv = 1'b0; dv = 1'b0; din = 8'h00; mode = 2'b11;
    tick(); tick(); tick();
    outs = {pix_valid, pix_data, pix_addr, mode_active, field_start,
            frame_done, line_err, field_err, busy};
    checks++; if (outs !== 36'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst = 1'b0;
    tick();
    // line_valid activity while idle must not start anything
    p = n_pix;
    line_begin();
    strobes(3, 8'h11);
    line_end();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_lv_busy: got %0b want 0", busy); end
    checks++; if (n_pix - p !== 0) begin errors++; $display("FAIL idle_lv_pix: got %0d want 0", n_pix - p); end
  endtask

  task automatic test_nominal_frame();
    int base, le0, fe0, fd0;
    do_reset();
    mode = 2'b01;
    base = n_pix; le0 = n_le; fe0 = n_fe; fd0 = n_fd;
    for (int f = 0; f < 2; f++) begin
      frame_begin();
      checks++; if (field_start !== 1'b1) begin errors++; $display("FAIL nom_field_start%0d: got %0b want 1", f, field_start); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy%0d: got %0b want 1", f, busy); end
      for (int r = 0; r < V; r++) begin
        line_begin();
        strobes(H, 8'(r * H + f * 128));
        line_end();
      end
      frame_end();
      checks++; if (frame_done !== 1'(f)) begin errors++; $display("FAIL nom_frame_done%0d: got %0b want %0b", f, frame_done, 1'(f)); end
      checks++; if (field_err !== 1'b0) begin errors++; $display("FAIL nom_field_err%0d: got %0b want 0", f, field_err); end
    end
    tick();
    checks++; if (n_pix - base !== 2 * V * H) begin errors++; $display("FAIL nom_pix_count: got %0d want %0d", n_pix - base, 2 * V * H); end
    checks++; if (addr_q[base] !== 20'h00000) begin errors++; $display("FAIL nom_first_addr: got %h want 00000", addr_q[base]); end
    checks++; if (addr_q[base + V * H] !== 20'h00400) begin errors++; $display("FAIL nom_f1_first_addr: got %h want 00400", addr_q[base + V * H]); end
    checks++; if (addr_q[base + 2 * V * H - 1] !== 20'h02C0F) begin errors++; $display("FAIL nom_last_addr: got %h want 02C0F", addr_q[base + 2 * V * H - 1]); end
    checks++; if (addr_q[base + 17] !== 20'h00801) begin errors++; $display("FAIL nom_r1c1_addr: got %h want 00801", addr_q[base + 17]); end
    checks++; if (data_q[base + 17] !== 8'd17) begin errors++; $display("FAIL nom_r1c1_data: got %h want 11", data_q[base + 17]); end
    checks++; if (data_q[base + V * H] !== 8'h80) begin errors++; $display("FAIL nom_f1_data: got %h want 80", data_q[base + V * H]); end
    checks++; if (n_fd - fd0 !== 1) begin errors++; $display("FAIL nom_frame_done_count: got %0d want 1", n_fd - fd0); end
    checks++; if (n_le - le0 + n_fe - fe0 !== 0) begin errors++; $display("FAIL nom_errors: got %0d want 0", n_le - le0 + n_fe - fe0); end
    checks++; if (mode_active !== 2'b01) begin errors++; $display("FAIL nom_mode: got %b want 01", mode_active); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy_end: got %0b want 0", busy); end
  endtask

  task automatic test_short_line();
    int p;
    do_reset();
    frame_begin();
    line_begin();
    p = n_pix;
    strobes(H - 2, 8'h00);
    line_end();
    checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL short_line_err: got %0b want 1", line_err); end
    tick();
    checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL short_line_err_width: got %0b want 0", line_err); end
    checks++; if (n_pix - p !== H - 2) begin errors++; $display("FAIL short_pix_count: got %0d want %0d", n_pix - p, H - 2); end
    line_begin();
    p = n_pix;
    strobes(1, 8'hA5);
    tick();
    checks++; if (n_pix - p !== 1) begin errors++; $display("FAIL short_next_count: got %0d want 1", n_pix - p); end
    checks++; if (addr_q[p] !== 20'h00800) begin errors++; $display("FAIL short_next_addr: got %h want 00800", addr_q[p]); end
    checks++; if (data_q[p] !== 8'hA5) begin errors++; $display("FAIL short_next_data: got %h want a5", data_q[p]); end
    line_end();
    frame_end();
    checks++; if (field_err !== 1'b1) begin errors++; $display("FAIL short_field_err: got %0b want 1", field_err); end
    tick();
  endtask

  task automatic test_long_line();
    int p;
    do_reset();
    frame_begin();
    line_begin();
    p = n_pix;
    strobes(H + 3, 8'h10);
    line_end();
    checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL long_line_err: got %0b want 1", line_err); end
    tick();
    checks++; if (n_pix - p !== H) begin errors++; $display("FAIL long_pix_count: got %0d want %0d", n_pix - p, H); end
    checks++; if (addr_q[p + H - 1] !== 20'h0000F) begin errors++; $display("FAIL long_last_addr: got %h want 0000f", addr_q[p + H - 1]); end
    checks++; if (data_q[p + H - 1] !== 8'h1F) begin errors++; $display("FAIL long_last_data: got %h want 1f", data_q[p + H - 1]); end
    frame_end();
    tick();
  endtask

  task automatic test_mode_latch();
    do_reset();
    mode = 2'b01;
    frame_begin();
    checks++; if (mode_active !== 2'b01) begin errors++; $display("FAIL mode_f0: got %b want 01", mode_active); end
    frame_end();
    mode = 2'b10;
    frame_begin();
    checks++; if (mode_active !== 2'b01) begin errors++; $display("FAIL mode_f1_hold: got %b want 01", mode_active); end
    frame_end();
    checks++; if (mode_active !== 2'b01) begin errors++; $display("FAIL mode_idle_hold: got %b want 01", mode_active); end
    frame_begin();
    checks++; if (mode_active !== 2'b10) begin errors++; $display("FAIL mode_next_frame: got %b want 10", mode_active); end
    frame_end();
    tick();
  endtask

  task automatic test_field_count();
    int p, le0;
    do_reset();
    frame_begin();
    full_lines(V - 1);
    frame_end();
    checks++; if (field_err !== 1'b1) begin errors++; $display("FAIL fc_short_field_err: got %0b want 1", field_err); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL fc_short_frame_done: got %0b want 0", frame_done); end
    tick();
    checks++; if (field_err !== 1'b0) begin errors++; $display("FAIL fc_field_err_width: got %0b want 0", field_err); end
    frame_begin();
    p = n_pix; le0 = n_le;
    full_lines(V + 2);
    frame_end();
    checks++; if (field_err !== 1'b1) begin errors++; $display("FAIL fc_long_field_err: got %0b want 1", field_err); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL fc_long_frame_done: got %0b want 1", frame_done); end
    tick();
    checks++; if (n_pix - p !== V * H) begin errors++; $display("FAIL fc_long_pix_count: got %0d want %0d", n_pix - p, V * H); end
    checks++; if (addr_q[p + V * H - 1] !== 20'h02C0F) begin errors++; $display("FAIL fc_long_last_addr: got %h want 02c0f", addr_q[p + V * H - 1]); end
    checks++; if (n_le - le0 !== 0) begin errors++; $display("FAIL fc_long_line_errs: got %0d want 0", n_le - le0); end
  endtask

  task automatic test_simultaneous_fall();
    do_reset();
    frame_begin();
    full_lines(V - 1);
    line_begin();
    strobes(H, 8'h00);
    fv = 1'b0; lv = 1'b0;
    tick();
    checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL sim_line_err: got %0b want 0", line_err); end
    checks++; if (field_err !== 1'b0) begin errors++; $display("FAIL sim_field_err: got %0b want 0", field_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sim_busy: got %0b want 0", busy); end
    // field 1: frame ends while the last line is still active
    frame_begin();
    full_lines(V - 1);
    line_begin();
    strobes(H, 8'h00);
    fv = 1'b0;
    tick();
    checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL abort_line_err: got %0b want 1", line_err); end
    checks++; if (field_err !== 1'b0) begin errors++; $display("FAIL abort_field_err: got %0b want 0", field_err); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL abort_frame_done: got %0b want 1", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", busy); end
    lv = 1'b0;
    tick();
    checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL abort_idle_lv_fall: got %0b want 0", line_err); end
  endtask

  task automatic test_reset_mid();
    int p;
    do_reset();
    mode = 2'b01;
    frame_begin();
    full_lines(2);
    line_begin();
    strobes(8, 8'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rmid_pix_valid: got %0b want 0", pix_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b want 0", busy); end
    checks++; if (mode_active !== 2'b00) begin errors++; $display("FAIL rmid_mode: got %b want 00", mode_active); end
    checks++; if ({pix_data, pix_addr} !== 28'h0) begin errors++; $display("FAIL rmid_data_addr: got %h want 0", {pix_data, pix_addr}); end
    p = n_pix;
    strobes(4, 8'h00);
    tick();
    checks++; if (n_pix - p !== 0) begin errors++; $display("FAIL rmid_ignored: got %0d want 0", n_pix - p); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_held: got %0b want 0", busy); end
    lv = 1'b0; fv = 1'b0;
    tick(); tick();
    frame_begin();
    checks++; if (field_start !== 1'b1) begin errors++; $display("FAIL rmid_field_start: got %0b want 1", field_start); end
    line_begin();
    p = n_pix;
    strobes(1, 8'h77);
    tick();
    checks++; if (n_pix - p !== 1) begin errors++; $display("FAIL rmid_restart_count: got %0d want 1", n_pix - p); end
    checks++; if (addr_q[p] !== 20'h00000) begin errors++; $display("FAIL rmid_restart_addr: got %h want 00000", addr_q[p]); end
    line_end();
    frame_end();
    tick();
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; fv = 1'b0; lv = 1'b0; dv = 1'b0; din = 8'h00;
    test_reset();
    test_nominal_frame();
    test_short_line();
    test_long_line();
    test_mode_latch();
    test_field_count();
    test_simultaneous_fall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_field_sequencer.md
Name: video_field_sequencer

Overview:
Front-end controller for the interlaced PAL capture path (702 px × 288 lines per field, 2 fields per frame). It tracks frame/line/data strobes, generates the packed pixel address {row, field, col}, and forwards qualified pixels to the processing datapath. It also latches the processing mode once per frame and flags framing errors. It sits between the camera/decoder video interface and the student processing block.

Parameters:
H_ACTIVE, 702, active pixels per line
V_ACTIVE, 288, active lines per field
COL_W, 10, column counter / address field width
ROW_W, 9, row counter / address field width

Ports:
clk  in  1  system clock (108 MHz domain)
rst  in  1  synchronous reset, active-high
mode_in  in  2  requested processing mode
video_frame_valid  in  1  high for the duration of one field
video_line_valid  in  1  high during one line's active region
video_data_valid  in  1  one-cycle pixel strobe
video_data_in  in  8  pixel value, valid with video_data_valid
pix_valid  out  1  qualified pixel strobe to datapath
pix_data  out  8  registered pixel value
pix_addr  out  ROW_W+1+COL_W  {row, field, col}
mode_active  out  2  mode applied to current frame
field_start  out  1  one-cycle pulse on each field start
frame_done  out  1  one-cycle pulse at end of field 1
line_err  out  1  one-cycle pulse: bad line length or aborted line
field_err  out  1  one-cycle pulse: line count ≠ V_ACTIVE at field end
busy  out  1  high while state ≠ IDLE

Behaviour:
- All inputs are synchronous to clk. Rise/fall detection uses a one-cycle registered delay of frame_valid and line_valid.
- Reset: state=IDLE, field index=0, row=0, col=0. All outputs 0, including mode_active=2'b00.
- FSM states: IDLE, FIELD, LINE.
  - IDLE → FIELD on frame_valid rise. field_start pulses. row=0.
  - If field index=0 on that rise, mode_active<=mode_in. mode_in is ignored at all other times.
  - FIELD → LINE on line_valid rise, while frame_valid is high. col=0.
  - LINE → FIELD on line_valid fall. line_err pulses if col≠H_ACTIVE. row increments and saturates at 2^ROW_W-1.
  - FIELD → IDLE on frame_valid fall. field_err pulses if row≠V_ACTIVE. field index toggles.
  - frame_done pulses when field index was 1 at that fall.
- Pixel qualification: in LINE with line_valid=1 and data_valid=1:
  - If col<H_ACTIVE and row<V_ACTIVE: next cycle pix_valid=1, pix_data=data_in, pix_addr={row[ROW_W-1:0], field, col}. Then col increments.
  - Otherwise the pixel is dropped and col keeps counting, saturating at 2^COL_W-1.
  - Latency is exactly 1 cycle. No backpressure.
- data_valid outside LINE, or in the cycle line_valid falls: ignored.
- Simultaneous line_valid fall and frame_valid fall: line closure is evaluated first (line_err), then field closure (field_err, frame_done). Both pulses may fire in the same cycle. Total result is LINE → IDLE.
- frame_valid fall while in LINE (line_valid still high): line aborted, line_err=1. row is incremented before the field check, so field_err is evaluated normally. Next state IDLE.
- line_valid rise in IDLE: ignored.
- rst mid-operation: outputs 0 on the next cycle and the FSM returns to IDLE. The next frame_valid rise starts field 0.

Decomposition:
- Package video_seq_pkg holds:
  - state enum {IDLE, FIELD, LINE}
  - constants PAL_H_ACTIVE=702, PAL_V_FIELD=288, ADDR_W=20
  - address-packing function
- One sub-module: video_edge_detect (registered level in; rise/fall pulses out), instantiated for frame_valid and line_valid.

Test Plan:
1. Nominal frame, default parameters, 2 fields × 288 lines × 702 strobes, mode_in=01 → 404352 pix_valid pulses.
   - First pix_addr=0x00000; field 1 first addr=0x00400; last addr=0x8FEBD.
   - frame_done pulses once; mode_active=01; no errors.
2. Line of 700 strobes → 700 pix_valid, line_err one cycle after line_valid falls. The next line's first addr has row+1, col=0.
3. Line of 705 strobes → exactly 702 pix_valid (cols 0–701), 3 dropped, line_err=1.
4. mode_in changes 01→10 during field 1 → mode_active stays 01 until the next field-0 frame_valid rise, then becomes 10.
5. Field of 287 lines → field_err pulses at frame_valid fall. Field of 290 lines → 288 lines forwarded, field_err=1.
6. rst pulsed mid-line (row 100, col 350) → the following cycle pix_valid=0, busy=0, field index 0. data_valid strobes are ignored until the next frame_valid rise, whose first addr=0x00000.
